// File: rtl/alu_pkg.sv
// Shared encodings and types for the execute-stage ALU.
package alu_pkg;

    localparam logic [5:0] ALU_OPCODE = 6'b100000;

    localparam logic [4:0] ADD   = 5'b00000;
    localparam logic [4:0] SUB   = 5'b00001;
    localparam logic [4:0] AND   = 5'b00010;
    localparam logic [4:0] XOR   = 5'b00011;
    localparam logic [4:0] OR    = 5'b00100;
    localparam logic [4:0] SLLI  = 5'b01000;
    localparam logic [4:0] SRLI  = 5'b01001;
    localparam logic [4:0] ROTRI = 5'b01011;
    localparam logic [4:0] NOP   = SRLI;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit for SLLI, SRLI and (with ALU_ROTATE_EN) ROTRI.
import alu_pkg::*;

module alu_shifter (
    input  word_t       value_i,
    input  logic [4:0]  amount_i,
    input  logic [4:0]  op_i,
    output word_t       result_o
);

`ifdef ALU_ROTATE_EN
    logic [63:0] rot_wide;

    // Shifting the doubled word right leaves the rotation in the low half.
    assign rot_wide = {value_i, value_i} >> amount_i;
`endif

    always_comb begin
        result_o = value_i;
        case (op_i)
            SLLI:    result_o = value_i << amount_i;
            SRLI:    result_o = value_i >> amount_i;
`ifdef ALU_ROTATE_EN
            ROTRI:   result_o = rot_wide[31:0];
`endif
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: add/sub with signed overflow, logic ops, shifts.
// Define ALU_ROTATE_EN to build ROTRI; otherwise that code holds the outputs.
import alu_pkg::*;

module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] scr1,
    input  logic [WIDTH-1:0] scr2,
    input  logic [5:0]       opcode,
    input  logic [4:0]       sub_opcode,
    input  logic             enable_execute,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_overflow
);

    word_t sum;
    word_t diff;
    word_t shift_res;
    word_t result_d, result_q;
    logic  ovf_d, ovf_q;

    assign sum  = scr1 + scr2;
    assign diff = scr1 - scr2;

    alu_shifter u_shifter (
        .value_i  (scr1),
        .amount_i (scr2[4:0]),
        .op_i     (sub_opcode),
        .result_o (shift_res)
    );

    always_comb begin
        result_d = result_q;
        ovf_d    = ovf_q;
        if (enable_execute && (opcode == ALU_OPCODE)) begin
            case (sub_opcode)
                ADD: begin
                    result_d = sum;
                    ovf_d    = (scr1[31] == scr2[31]) && (sum[31] != scr1[31]);
                end
                SUB: begin
                    result_d = diff;
                    ovf_d    = (scr1[31] != scr2[31]) && (diff[31] != scr1[31]);
                end
                AND: begin
                    result_d = scr1 & scr2;
                    ovf_d    = 1'b0;
                end
                XOR: begin
                    result_d = scr1 ^ scr2;
                    ovf_d    = 1'b0;
                end
                OR: begin
                    result_d = scr1 | scr2;
                    ovf_d    = 1'b0;
                end
                SLLI, SRLI: begin
                    result_d = shift_res;
                    ovf_d    = 1'b0;
                end
`ifdef ALU_ROTATE_EN
                ROTRI: begin
                    result_d = shift_res;
                    ovf_d    = 1'b0;
                end
`endif
                // Undefined sub-opcodes leave both outputs untouched.
                default: begin
                    result_d = result_q;
                    ovf_d    = ovf_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign alu_result   = result_q;
    assign alu_overflow = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops against an arithmetic model.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] scr1 = '0;
    logic [31:0] scr2 = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  sub_opcode = '0;
    logic        enable_execute = 1'b0;
    logic [31:0] alu_result;
    logic        alu_overflow;

    localparam logic [5:0] AluOp = 6'b100000;

    always #5 clk = ~clk;

    alu dut (
        .clk            (clk),
        .reset          (reset),
        .scr1           (scr1),
        .scr2           (scr2),
        .opcode         (opcode),
        .sub_opcode     (sub_opcode),
        .enable_execute (enable_execute),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] m_res = '0;
    logic        m_ovf = 1'b0;

`ifdef ALU_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference behaviour from plain integer arithmetic; returns 0 for undefined codes.
    function automatic bit model_op(input logic [4:0] sub, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic o);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          s;
        longint unsigned ua = 64'(a);
        longint unsigned pw = 1;
        longint unsigned t;
        int              sh = int'(b[4:0]);
        for (int i = 0; i < sh; i++) pw = pw * 2;
        r = '0;
        o = 1'b0;
        case (sub)
            5'd0: begin
                s = sa + sb;
                t = 64'(s);
                r = t[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd1: begin
                s = sa - sb;
                t = 64'(s);
                r = t[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd2: for (int i = 0; i < 32; i++) r[i] = a[i] && b[i];
            5'd3: for (int i = 0; i < 32; i++) r[i] = a[i] != b[i];
            5'd4: for (int i = 0; i < 32; i++) r[i] = a[i] || b[i];
            5'd8: begin
                t = ua * pw;
                r = t[31:0];
            end
            5'd9: begin
                t = ua / pw;
                r = t[31:0];
            end
            5'd11: begin
                if (!RotEn) return 1'b0;
                t = ua / pw + (ua * 64'd4294967296) / pw;
                r = t[31:0];
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic step(input logic rst, input logic en, input logic [5:0] opc,
                        input logic [4:0] sub, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        logic [31:0] r;
        logic        o;
        bit          v;
        reset          = rst;
        enable_execute = en;
        opcode         = opc;
        sub_opcode     = sub;
        scr1           = a;
        scr2           = b;
        @(posedge clk);
        #1;
        v = model_op(sub, a, b, r, o);
        if (rst) begin
            m_res = '0;
            m_ovf = 1'b0;
        end else if (en && opc == AluOp && v) begin
            m_res = r;
            m_ovf = o;
        end
        check_eq({tag, "/res"}, alu_result, m_res);
        check_eq({tag, "/ovf"}, {31'd0, alu_overflow}, {31'd0, m_ovf});
    endtask

    logic [4:0] codes [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd11, 5'd31, 5'd5};

    initial begin
        step(1'b1, 1'b0, AluOp, 5'd0, 32'h0, 32'h0, "reset");
        check_eq("reset_lit", alu_result, 32'h0);
        step(1'b0, 1'b1, AluOp, 5'd0, 32'hFFFFFF00, 32'h5, "add_first");
        check_eq("add_first_lit", alu_result, 32'hFFFFFF05);

        step(1'b0, 1'b1, AluOp, 5'd0, 32'h7FFFFFFF, 32'h1, "add_ovf");
        check_eq("add_ovf_lit", {alu_overflow, alu_result[30:0]}, 32'h80000000);
        step(1'b0, 1'b1, AluOp, 5'd1, 32'h80000000, 32'h1, "sub_ovf");
        check_eq("sub_ovf_lit", {31'd0, alu_overflow}, 32'h1);
        step(1'b0, 1'b1, AluOp, 5'd1, 32'h5, 32'h7, "sub_neg");
        check_eq("sub_neg_lit", alu_result, 32'hFFFFFFFE);

        step(1'b0, 1'b1, AluOp, 5'd2, 32'hF0F0F0F0, 32'hFF00FF00, "and");
        check_eq("and_lit", alu_result, 32'hF000F000);
        step(1'b0, 1'b1, AluOp, 5'd4, 32'hF0F0F0F0, 32'hFF00FF00, "or");
        check_eq("or_lit", alu_result, 32'hFFF0FFF0);
        step(1'b0, 1'b1, AluOp, 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, "xor");
        check_eq("xor_lit", alu_result, 32'h0FF00FF0);

        step(1'b0, 1'b1, AluOp, 5'd8, 32'h1, 32'd31, "slli31");
        check_eq("slli31_lit", alu_result, 32'h80000000);
        step(1'b0, 1'b1, AluOp, 5'd9, 32'h80000000, 32'd4, "srli4");
        check_eq("srli4_lit", alu_result, 32'h08000000);
        step(1'b0, 1'b1, AluOp, 5'd11, 32'h1, 32'd1, "rotri1");
        check_eq("rotri1_lit", alu_result, RotEn ? 32'h80000000 : 32'h08000000);
        step(1'b0, 1'b1, AluOp, 5'd9, 32'h1234ABCD, 32'hFFFFFFE0, "srli0");
        check_eq("srli0_lit", alu_result, 32'h1234ABCD);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, AluOp, 5'd0, 32'h11111111, 32'h22222222, "hold_en");
            check_eq("hold_en_lit", alu_result, 32'h1234ABCD);
        end
        step(1'b0, 1'b1, AluOp, 5'd31, 32'h11111111, 32'h22222222, "hold_undef");
        check_eq("hold_undef_lit", alu_result, 32'h1234ABCD);
        step(1'b0, 1'b1, 6'b000011, 5'd0, 32'h11111111, 32'h22222222, "hold_opc");
        check_eq("hold_opc_lit", alu_result, 32'h1234ABCD);

        step(1'b1, 1'b1, AluOp, 5'd0, 32'h1, 32'h1, "rst_prio");
        check_eq("rst_prio_lit", alu_result, 32'h0);
        step(1'b0, 1'b1, AluOp, 5'd0, 32'h1, 32'h1, "after_rst");
        check_eq("after_rst_lit", alu_result, 32'h2);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  sub;
            logic [5:0]  opc;
            logic [31:0] a;
            logic [31:0] b;
            sub = codes[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) sub = 5'($urandom);
            opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : AluOp;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) != 0), opc, sub, a, b,
                 "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
